// File: rtl/csr_counter_unit_pkg.sv
// csr_counter_unit_pkg: CSR op encoding, counter CSR addresses and the shared read-modify-write helper
package csr_counter_unit_pkg;
   typedef enum logic [1:0] {CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_t;
   localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_ADDR_MHPMEVENT3 = 12'h323;
   localparam logic [11:0] CSR_ADDR_MCYCLE = 12'hB00;
   localparam logic [11:0] CSR_ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3 = 12'hB03;
   localparam logic [11:0] CSR_ADDR_MCYCLEH = 12'hB80;
   localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_ADDR_CYCLE = 12'hC00;
   localparam logic [11:0] CSR_ADDR_INSTRET = 12'hC02;
   localparam logic [11:0] CSR_ADDR_HPMCOUNTER3 = 12'hC03;
   localparam logic [11:0] CSR_ADDR_CYCLEH = 12'hC80;
   localparam logic [11:0] CSR_ADDR_INSTRETH = 12'hC82;
   localparam logic [11:0] CSR_ADDR_HPMCOUNTER3H = 12'hC83;
   function automatic logic [31:0] csr_apply_op(csr_op_t op, logic [31:0] old, logic [31:0] wdata);
      return op == CSR_WRITE ? wdata : op == CSR_SET ? (old | wdata) : op == CSR_CLEAR ? (old & ~wdata) : old;
   endfunction
endpackage

// File: rtl/csr_counter_unit_if.sv
// csr_counter_unit_if: WB-stage CSR access bus into the counter block
interface csr_counter_unit_if;
   import csr_counter_unit_pkg::*;
   logic        valid;
   csr_op_t     op;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic        illegal;
   modport master (output valid, op, addr, wdata, input rdata, hit, illegal);
   modport slave (input valid, op, addr, wdata, output rdata, hit, illegal);
endinterface

// File: rtl/csr_counter_unit_slice.sv
// csr_counter_unit_slice: one wide counter with half-word writes that win over the increment
module csr_counter_unit_slice #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inhibit,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] cnt
);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt <= '0;
      else if (wr_lo) cnt[31:0] <= wdata;
      else if (wr_hi) cnt[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      else if (inc && !inhibit) cnt <= cnt + CNT_WIDTH'(1);
endmodule

// File: rtl/csr_counter_unit.sv
// csr_counter_unit: mcycle/minstret/mhpmcounters with mcountinhibit; CSR_CNT_USER_VIEW_EN adds read-only user aliases
module csr_counter_unit
   import csr_counter_unit_pkg::*;
#(
   parameter int NUM_HPM    = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   csr_counter_unit_if.slave     bus,
   input  logic                  instr_retire_i,
   input  logic [NUM_EVENTS-1:0] event_i
);
   localparam int NC = NUM_HPM + 2;
   localparam int EW = $clog2(NUM_EVENTS + 1);
   localparam int EVW = 2 ** EW;
   localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
   logic [CNT_WIDTH-1:0] cnt [NC];
   logic [CNT_WIDTH-1:0] cnt_at [32];
   logic [31:0]          reg_at [32];
   logic [31:0]          inh;
   logic [EW-1:0]        evt_sel [NUM_HPM];
   logic [EVW-1:0]       ev_ext;
   logic [NC-1:0]        inc;
   logic [4:0]           off;
   logic                 m_lo, m_hi, u_lo, u_hi, evt_rg, cnt_rg, wr;
   logic [31:0]          rd, nv;
   assign off = bus.addr[4:0];
   assign m_lo = bus.addr[11:5] == CSR_ADDR_MCYCLE[11:5];
   assign m_hi = bus.addr[11:5] == CSR_ADDR_MCYCLEH[11:5];
`ifdef CSR_CNT_USER_VIEW_EN
   assign u_lo = bus.addr[11:5] == CSR_ADDR_CYCLE[11:5];
   assign u_hi = bus.addr[11:5] == CSR_ADDR_CYCLEH[11:5];
`else
   assign u_lo = 1'b0;
   assign u_hi = 1'b0;
`endif
   assign evt_rg = bus.addr[11:5] == CSR_ADDR_MCOUNTINHIBIT[11:5];
   assign cnt_rg = m_lo | m_hi | u_lo | u_hi;
   assign wr = bus.valid && bus.op != CSR_NONE;
   // bit 0 of the padded strobe vector is selector 0, which never counts
   assign ev_ext = EVW'({event_i, 1'b0});
   always_comb begin
      for (int k = 0; k < 32; k++) begin
         cnt_at[k] = '0;
         reg_at[k] = '0;
      end
      cnt_at[0] = cnt[0];
      cnt_at[2] = cnt[1];
      reg_at[0] = inh;
      for (int i = 0; i < NUM_HPM; i++) begin
         cnt_at[3+i] = cnt[2+i];
         reg_at[3+i] = 32'(evt_sel[i]);
      end
   end
   assign rd = evt_rg ? reg_at[off] : (m_lo | u_lo) ? cnt_at[off][31:0] : (m_hi | u_hi) ? 32'(cnt_at[off][CNT_WIDTH-1:32]) : '0;
   assign nv = csr_apply_op(bus.op, rd, bus.wdata);
   assign bus.rdata = bus.valid ? rd : '0;
   assign bus.hit = bus.valid && ((evt_rg && off != 5'd1 && off != 5'd2) || (cnt_rg && off != 5'd1));
   assign bus.illegal = wr && (u_lo | u_hi) && off != 5'd1;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         inh <= '0;
         for (int i = 0; i < NUM_HPM; i++) evt_sel[i] <= '0;
      end else if (wr && evt_rg) begin
         if (off == 5'd0) inh <= nv & INH_MASK;
         for (int i = 0; i < NUM_HPM; i++) if (off == 5'(3 + i)) evt_sel[i] <= nv[EW-1:0];
      end
   for (genvar j = 0; j < NC; j++) begin : g_cnt
      localparam int O = j == 0 ? 0 : j + 1;
      if (j == 0) begin : g_cy
         assign inc[j] = 1'b1;
      end else if (j == 1) begin : g_ir
         assign inc[j] = instr_retire_i;
      end else begin : g_hpm
         assign inc[j] = ev_ext[evt_sel[j-2]];
      end
      csr_counter_unit_slice #(.CNT_WIDTH(CNT_WIDTH)) u_slice (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .inhibit (inh[O]),
         .inc     (inc[j]),
         .wr_lo   (wr && m_lo && off == 5'(O)),
         .wr_hi   (wr && m_hi && off == 5'(O)),
         .wdata   (nv),
         .cnt     (cnt[j])
      );
   end
endmodule

// File: tb/tb_csr_counter_unit.sv
// tb_csr_counter_unit: directed vectors checked against an address-level behavioural model every cycle
module tb_csr_counter_unit;
   import csr_counter_unit_pkg::*;
`ifdef CSR_CNT_USER_VIEW_EN
   localparam bit UV = 1'b1;
`else
   localparam bit UV = 1'b0;
`endif
   localparam int NH = 4;
   localparam int NE = 8;
   logic clk = 1'b0;
   logic rst_n;
   logic retire;
   logic [NE-1:0] ev;
   int checks = 0;
   int failures = 0;
   csr_counter_unit_if bus ();
   csr_counter_unit #(.NUM_HPM(NH), .CNT_WIDTH(64), .NUM_EVENTS(NE)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus            (bus),
      .instr_retire_i (retire),
      .event_i        (ev)
   );
   always #5 clk = ~clk;
   logic [63:0] mc [32];
   logic [31:0] msel [32];
   logic [31:0] minh;
   function automatic bit impl(int k);
      return k == 0 || k == 2 || (k >= 3 && k < 3 + NH);
   endfunction
   function automatic logic [32:0] mread(logic [11:0] a);
      int k;
      logic [11:0] base;
      k = int'(a[4:0]);
      base = a & 12'hFE0;
      if (a == 12'h320) return {1'b1, minh};
      if (a >= 12'h323 && a <= 12'h33F) return {1'b1, msel[k]};
      if (k != 1 && (base == 12'hB00 || (UV && base == 12'hC00))) return {1'b1, mc[k][31:0]};
      if (k != 1 && (base == 12'hB80 || (UV && base == 12'hC80))) return {1'b1, mc[k][63:32]};
      return '0;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      logic [32:0] r;
      logic [31:0] nv;
      logic [11:0] base;
      int k, s;
      bit w, hit_cnt, up;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mc[i] = '0;
            msel[i] = '0;
         end
         minh = '0;
      end else begin
         k = int'(bus.addr[4:0]);
         base = bus.addr & 12'hFE0;
         w = bus.valid && bus.op != CSR_NONE;
         r = mread(bus.addr);
         nv = bus.op == CSR_WRITE ? bus.wdata : bus.op == CSR_SET ? (r[31:0] | bus.wdata) : (r[31:0] & ~bus.wdata);
         for (int j = 0; j < 32; j++) begin
            s = int'(msel[j]);
            if (j == 0) up = 1'b1;
            else if (j == 2) up = retire;
            else up = s >= 1 && s <= NE && ev[s-1];
            hit_cnt = w && (base == 12'hB00 || base == 12'hB80) && k == j;
            if (impl(j) && !minh[j] && up && !hit_cnt) mc[j] = mc[j] + 64'd1;
         end
         if (w) begin
            if (bus.addr == 12'h320) minh = nv & 32'h0000_007D;
            else if (bus.addr >= 12'h323 && bus.addr <= 12'h33F && k < 3 + NH) msel[k] = nv & 32'hF;
            else if (base == 12'hB00 && impl(k)) mc[k][31:0] = nv;
            else if (base == 12'hB80 && impl(k)) mc[k][63:32] = nv;
         end
      end
   end
   always @(negedge clk) begin
      logic [32:0] m;
      logic ei;
      logic [11:0] base;
      if (rst_n) begin
         base = bus.addr & 12'hFE0;
         m = bus.valid ? mread(bus.addr) : '0;
         ei = bus.valid && bus.op != CSR_NONE && UV && bus.addr[4:0] != 5'd1 && (base == 12'hC00 || base == 12'hC80);
         checks++;
         if (bus.hit !== m[32] || bus.rdata !== m[31:0] || bus.illegal !== ei) begin
            failures++;
            $display("FAIL model addr=%h: got hit=%b data=%h ill=%b, want hit=%b data=%h ill=%b", bus.addr, bus.hit, bus.rdata, bus.illegal, m[32], m[31:0], ei);
         end
      end
   end
   task automatic drive(input logic v, input csr_op_t o, input logic [11:0] a, input logic [31:0] d, input logic r, input logic [NE-1:0] e);
      @(posedge clk);
      #1;
      bus.valid = v;
      bus.op = o;
      bus.addr = a;
      bus.wdata = d;
      retire = r;
      ev = e;
   endtask
   task automatic idle(input int n);
      repeat (n) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b0, '0);
   endtask
   task automatic rd_chk(input logic [11:0] a, input logic [31:0] d, input logic h, input string name);
      drive(1'b1, CSR_NONE, a, 32'h0, 1'b0, '0);
      @(negedge clk);
      checks++;
      if (bus.rdata !== d || bus.hit !== h) begin
         failures++;
         $display("FAIL %s: got hit=%b data=%h, want hit=%b data=%h", name, bus.hit, bus.rdata, h, d);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      bus.valid = 1'b0;
      bus.op = CSR_NONE;
      bus.addr = '0;
      bus.wdata = '0;
      retire = 1'b0;
      ev = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(9);
      rd_chk(12'hB00, 32'd10, 1'b1, "mcycle_10");
      rd_chk(12'hB80, 32'd0, 1'b1, "mcycleh_0");
      rd_chk(12'hB02, 32'd0, 1'b1, "minstret_0");
      drive(1'b1, CSR_WRITE, 12'hB00, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b1, CSR_WRITE, 12'hB80, 32'hFFFF_FFFF, 1'b0, '0);
      idle(2);
      rd_chk(12'hB00, 32'd1, 1'b1, "wrap_lo");
      rd_chk(12'hB80, 32'd0, 1'b1, "wrap_hi");
      drive(1'b1, CSR_WRITE, 12'hB00, 32'h100, 1'b0, '0);
      drive(1'b1, CSR_SET, 12'h320, 32'h5, 1'b0, '0);
      repeat (3) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b1, '0);
      rd_chk(12'h320, 32'h5, 1'b1, "inhibit_set");
      rd_chk(12'hB00, 32'h101, 1'b1, "cy_frozen");
      rd_chk(12'hB02, 32'h0, 1'b1, "ir_frozen");
      drive(1'b1, CSR_CLEAR, 12'h320, 32'h5, 1'b0, '0);
      rd_chk(12'hB00, 32'h101, 1'b1, "cy_old_inhibit");
      rd_chk(12'hB00, 32'h102, 1'b1, "cy_resumed");
      drive(1'b1, CSR_WRITE, 12'h323, 32'd2, 1'b0, '0);
      repeat (7) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b0, 8'h02);
      repeat (3) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b0, 8'h01);
      rd_chk(12'hB03, 32'd7, 1'b1, "hpm3_event2");
      drive(1'b1, CSR_WRITE, 12'h323, 32'd9, 1'b0, '0);
      repeat (3) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b0, 8'hFF);
      rd_chk(12'hB03, 32'd7, 1'b1, "hpm3_sel9_idle");
      rd_chk(12'h323, 32'd9, 1'b1, "mhpmevent3_9");
      drive(1'b1, CSR_WRITE, 12'h323, 32'd8, 1'b0, '0);
      repeat (2) drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b0, 8'h80);
      rd_chk(12'hB03, 32'd9, 1'b1, "hpm3_sel8");
      drive(1'b1, CSR_WRITE, 12'h323, 32'hFFFF_FFF3, 1'b0, '0);
      rd_chk(12'h323, 32'h3, 1'b1, "mhpmevent_trunc");
      drive(1'b1, CSR_WRITE, 12'h320, 32'hFFFF_FFFF, 1'b0, '0);
      rd_chk(12'h320, 32'h7D, 1'b1, "inhibit_mask");
      drive(1'b1, CSR_CLEAR, 12'h320, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b1, CSR_WRITE, 12'hB02, 32'h100, 1'b1, '0);
      rd_chk(12'hB02, 32'h100, 1'b1, "write_beats_retire");
      drive(1'b1, CSR_SET, 12'hB02, 32'h3, 1'b1, '0);
      drive(1'b1, CSR_CLEAR, 12'hB02, 32'h1, 1'b0, '0);
      drive(1'b0, CSR_NONE, 12'h0, 32'h0, 1'b1, '0);
      rd_chk(12'hB02, 32'h103, 1'b1, "set_clear_retire");
      drive(1'b1, CSR_WRITE, 12'hB1F, 32'hABC, 1'b0, '0);
      rd_chk(12'hB1F, 32'h0, 1'b1, "unimpl_hpm");
      rd_chk(12'hB01, 32'h0, 1'b0, "b01_miss");
      rd_chk(12'h33F, 32'h0, 1'b1, "unimpl_evt");
      rd_chk(12'h7C0, 32'h0, 1'b0, "foreign_miss");
      drive(1'b1, CSR_WRITE, 12'hC02, 32'h55, 1'b0, '0);
      @(negedge clk);
      checks++;
      if (bus.illegal !== UV) begin
         failures++;
         $display("FAIL alias_write_illegal: got %b want %b", bus.illegal, UV);
      end
      rd_chk(12'hB02, 32'h103, 1'b1, "alias_write_ignored");
      rd_chk(12'hC82, 32'h0, UV, "instreth_alias");
      drive(1'b1, CSR_NONE, 12'hB00, 32'h0, 1'b0, '0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rdata !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: got %h want 0", bus.rdata);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      rd_chk(12'hB00, 32'd1, 1'b1, "resume_after_reset");
      rd_chk(12'hB02, 32'd0, 1'b1, "minstret_reset");
      rd_chk(12'h323, 32'd0, 1'b1, "mhpmevent_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
